// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder (cla_pipe).
// Holds configuration defaults, the stage-count helper and the per-stage control record.
package cla_pkg;

  localparam int CLA_WIDTH_DEF = 32;
  localparam int CLA_SEG_W_DEF = 8;

  // Width-independent part of a stage record; the operand/sum fields depend on
  // WIDTH and are wrapped around this inside cla_pipe.
  typedef struct packed {
    logic valid;
    logic carry;
    logic cmsb;
  } cla_ctl_t;

  function automatic int seg_count(input int width, input int seg_w);
    return (seg_w < 1) ? 1 : width / seg_w;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead group: sum, group carry-out and the
// carry into the group's MSB (needed for signed overflow in the last stage).
module cla_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SEG_W-1:0] p;
  logic [SEG_W-1:0] g;
  logic [SEG_W:0]   c;
  logic             acc;
  logic             run;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products over the generate/propagate terms
  // below it, so no carry depends on another computed carry.
  always_comb begin
    c   = '0;
    acc = 1'b0;
    run = 1'b1;
    for (int i = 0; i <= SEG_W; i++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (g[j] & run);
        run = run & p[j];
      end
      c[i] = acc | (run & cin);
    end
  end

  assign sum  = p ^ c[SEG_W-1:0];
  assign cout = c[SEG_W];
  assign cmsb = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one SEG_W-bit segment per stage.
// Optional macro CLA_PIPE_SAT_EN saturates out_sum to the signed limit on overflow.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH_DEF,
  parameter int SEG_W = CLA_SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = seg_count(WIDTH, SEG_W);

  typedef struct packed {
    cla_ctl_t         ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_param_check
    $error("cla_pipe: WIDTH must be a positive multiple of SEG_W");
  end

  logic   adv;
  stage_t head;
  stage_t stg_q [NSEG];
  stage_t stg_d [NSEG];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1, so the operand is inverted once at accept and
  // every stage only ever adds.
  always_comb begin
    head           = '0;
    head.ctl.valid = in_valid & in_ready;
    head.ctl.carry = in_sub | in_cin;
    head.a         = in_a;
    head.b         = in_sub ? ~in_b : in_b;
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    stage_t           st_in;
    stage_t           st_out;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_cout;
    logic             seg_cmsb;

    if (k == 0) begin : g_first
      assign st_in = head;
    end else begin : g_next
      assign st_in = stg_q[k-1];
    end

    cla_seg #(.SEG_W(SEG_W)) u_seg (
      .a    (st_in.a[k*SEG_W +: SEG_W]),
      .b    (st_in.b[k*SEG_W +: SEG_W]),
      .cin  (st_in.ctl.carry),
      .sum  (seg_sum),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_comb begin
      st_out                          = st_in;
      st_out.sum[k*SEG_W +: SEG_W]    = seg_sum;
      st_out.ctl.carry                = seg_cout;
      st_out.ctl.cmsb                 = seg_cmsb;
`ifdef CLA_PIPE_SAT_EN
      // On overflow both operand signs agree, so A's sign picks the limit.
      if (k == NSEG - 1 && (seg_cout ^ seg_cmsb)) begin
        st_out.sum = {st_in.a[WIDTH-1], {(WIDTH-1){~st_in.a[WIDTH-1]}}};
      end
`endif
    end

    assign stg_d[k] = st_out;
  end

  // The whole pipe moves as one; bubbles stay where they are.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        stg_q[i] <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < NSEG; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  assign out_valid = stg_q[NSEG-1].ctl.valid;
  assign out_sum   = stg_q[NSEG-1].sum;
  assign out_cout  = stg_q[NSEG-1].ctl.carry;
  assign out_ovf   = stg_q[NSEG-1].ctl.carry ^ stg_q[NSEG-1].ctl.cmsb;

  logic unused_tail;
  assign unused_tail = ^{stg_q[NSEG-1].a, stg_q[NSEG-1].b};

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 2-bit CLA cell.
- Splits a WIDTH-bit operation into NSEG segments of SEG_W bits. Each segment is a combinational CLA group resolved in its own pipeline stage; the carry is registered between stages and not-yet-used operand bits are carried forward.
- Valid/ready stream interface with backpressure. Sits between the operand-fetch and result-writeback stages of the adder_flex datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG_W.
- SEG_W, 8, bits per CLA segment and per pipeline stage. SEG_W = WIDTH gives a single-stage adder.
- NSEG (localparam), WIDTH/SEG_W, number of stages; equals latency in cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (ignored when in_sub=1)
- in_sub  in  1  1 = A-B, 0 = A+B+cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  sum/difference
- out_cout  out  1  raw carry-out of MSB (borrow = ~out_cout when sub)
- out_ovf  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values: all stage valid bits 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0. in_ready is 1 from the first cycle after rst deasserts.
- Reset mid-operation: all in-flight beats are discarded with no partial output.
- Operand conditioning at accept:
  - b_eff = in_sub ? ~in_b : in_b
  - c0 = in_sub ? 1 : in_cin
- Stall rule: adv = out_ready | ~out_valid.
  - All stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv (combinational from out_ready and out_valid).
  - A beat is accepted when in_valid & in_ready.
- Bubbles: an empty accept slot inserts a bubble (valid=0) that occupies a stage. Bubbles are not compacted.
- Stage k (k = 0..NSEG-1) on adv:
  - Computes bits [k*SEG_W +: SEG_W] using a SEG_W-bit CLA (p=a^b, g=a&b, full lookahead within the segment) and the incoming registered carry.
  - Registers those sum bits, the segment carry-out, and the remaining upper operand bits.
- Latency: exactly NSEG cycles from accept to out_valid with no stalls. Throughput is 1 beat/cycle.
- Output stability: out_* hold stable while out_valid & ~out_ready.
- Arithmetic:
  - out_sum = (A + b_eff + c0) mod 2^WIDTH
  - out_cout = carry out of bit WIDTH-1
  - out_ovf = carry into MSB XOR carry out of MSB. This is computed in the final stage; the final stage also registers the MSB carry-in.
- Wrap-around: 0xFF..F + 1 gives sum 0, cout 1, ovf 0.
- Simultaneous accept and output handshake in the same cycle is legal. Full throughput is sustained when out_ready=1 continuously.
- Parameter checks: an elaboration-time assertion fails if WIDTH % SEG_W != 0 or SEG_W < 1.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN
- Defined: when the final-stage ovf=1, out_sum is replaced by the saturated signed value: 0111..1 if A[MSB]=0, 1000..0 if A[MSB]=1. A[MSB] and b_eff[MSB] are equal whenever overflow occurs. out_cout and out_ovf are unchanged (ovf still reports the event).
- Undefined: out_sum is always the wrapped result; no saturation logic is present.

Decomposition:
- Package cla_pkg:
  - function seg_count(width, seg_w)
  - typedef struct per-stage record: valid, carry, partial sum, remaining a/b
  - localparam defaults for WIDTH/SEG_W
- Sub-module cla_seg:
  - Combinational, SEG_W-parametrised lookahead group.
  - Outputs: sum, group carry-out, carry into its MSB (used for ovf).
  - Instantiated NSEG times by a generate loop.

Test Plan (WIDTH=16, SEG_W=4, latency 4):
- Add: a=0x1234, b=0x0FCD, cin=0, sub=0 -> after 4 cycles sum=0x2201, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. This checks carry propagation across all 4 stages.
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow).
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1. With CLA_PIPE_SAT_EN, sum=0x7FFF.
- Backpressure: stream 8 back-to-back beats a=i, b=i. Hold out_ready=0 for cycles 5-7 -> in_ready=0 while stalled, out_sum=0x0000 held stable, no beat lost or duplicated, results 2*i appear in order.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> out_valid=0 immediately; no stale result appears afterwards; a new beat 0x0001+0x0001 yields 0x0002 after 4 cycles.
